// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath widths, ALU opcodes and the
// control bits carried through the EX stage.
package cpu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b1111;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
    } ex_ctrl_t;

    // Side-effecting control bits are dropped for an empty decode slot;
    // memtoreg only steers the writeback mux, so it passes through.
    function automatic ex_ctrl_t qualify_ctrl(input logic valid, input ex_ctrl_t c);
        ex_ctrl_t q;
        q          = c;
        q.regwrite = c.regwrite & valid;
        q.memread  = c.memread  & valid;
        q.memwrite = c.memwrite & valid;
        q.branch   = c.branch   & valid;
        return q;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one source register.
// Ports: i_idx (registered source index), i_rf_val (registered register-file
// value), i_exmem_* / i_memwb_* (producer index, write enable, result),
// o_val (forwarded operand). EX/MEM takes precedence over MEM/WB; index 0
// never forwards.
module fwd_mux #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_idx,
    input  logic [XLEN-1:0]   i_rf_val,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic              i_exmem_we,
    input  logic [XLEN-1:0]   i_exmem_val,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic              i_memwb_we,
    input  logic [XLEN-1:0]   i_memwb_val,
    output logic [XLEN-1:0]   o_val
);

    logic w_nonzero;
    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_nonzero   = (i_idx != '0);
    assign w_hit_exmem = i_exmem_we && (i_exmem_rd == i_idx) && w_nonzero;
    assign w_hit_memwb = i_memwb_we && (i_memwb_rd == i_idx) && w_nonzero;

    always_comb begin
        o_val = i_rf_val;
        if (w_hit_exmem) begin
            o_val = i_exmem_val;
        end else if (w_hit_memwb) begin
            o_val = i_memwb_val;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Latches decoded operands and
// control, forwards EX/MEM and MEM/WB results onto the registered operands,
// selects the immediate for data2 and detects load-use hazards.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_*                            decoded instruction from the ID stage
//   stall, flush                    global freeze / squash of the EX entry
//   exmem_*, memwb_*                forwarding producers
//   alu_data1, alu_data2, alu_op    ALU operands and operation
//   ex_store_data                   forwarded rs2 for stores
//   ex_rd, ex_valid, ex_<ctrl>      registered destination and control
//   hazard_stall                    hold PC and IF/ID this cycle
//   stall_count                     hazard cycle counter (ID_EX_STALL_CNT_EN only)
// Optional feature macro: ID_EX_STALL_CNT_EN adds a saturating counter of
// cycles with hazard_stall asserted.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN   = cpu_pkg::XLEN,
    parameter int unsigned REG_AW = cpu_pkg::REG_AW
`ifdef ID_EX_STALL_CNT_EN
    ,
    parameter int unsigned STALL_CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_rs1_val,
    input  logic [XLEN-1:0]   id_rs2_val,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_aluop,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              id_branch,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_regwrite,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_regwrite,
    input  logic [XLEN-1:0]   memwb_result,
    output logic [XLEN-1:0]   alu_data1,
    output logic [XLEN-1:0]   alu_data2,
    output logic [3:0]        alu_op,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_branch,
    output logic              hazard_stall
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    logic              r_valid;
    ex_ctrl_t          r_ctrl;
    logic [XLEN-1:0]   r_rs1_val;
    logic [XLEN-1:0]   r_rs2_val;
    logic [XLEN-1:0]   r_imm;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic [3:0]        r_aluop;
    logic              r_alusrc;

    ex_ctrl_t          w_id_ctrl;
    logic              w_hazard;
    logic              w_bubble;
    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;

    assign w_id_ctrl = qualify_ctrl(id_valid, '{regwrite: id_regwrite,
                                                memread:  id_memread,
                                                memwrite: id_memwrite,
                                                memtoreg: id_memtoreg,
                                                branch:   id_branch});

    // Load in EX whose destination is read by the instruction now in decode.
    assign w_hazard = !flush && r_valid && r_ctrl.memread && (r_rd != '0) &&
                      id_valid && ((r_rd == id_rs1) || (r_rd == id_rs2));

    // Hazard bubbles are held off by stall; flush always wins.
    assign w_bubble = flush || (!stall && w_hazard);

    // Pipeline register: flush > stall > hazard bubble > capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_aluop   <= ALU_ADD;
            r_alusrc  <= 1'b0;
        end else if (w_bubble) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_aluop   <= ALU_ADD;
            r_alusrc  <= 1'b0;
        end else if (!stall) begin
            r_valid   <= id_valid;
            r_ctrl    <= w_id_ctrl;
            r_rs1_val <= id_rs1_val;
            r_rs2_val <= id_rs2_val;
            r_imm     <= id_imm;
            r_rs1     <= id_rs1;
            r_rs2     <= id_rs2;
            r_rd      <= id_rd;
            r_aluop   <= id_aluop;
            r_alusrc  <= id_alusrc;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .i_idx       (r_rs1),
        .i_rf_val    (r_rs1_val),
        .i_exmem_rd  (exmem_rd),
        .i_exmem_we  (exmem_regwrite),
        .i_exmem_val (exmem_result),
        .i_memwb_rd  (memwb_rd),
        .i_memwb_we  (memwb_regwrite),
        .i_memwb_val (memwb_result),
        .o_val       (w_fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .i_idx       (r_rs2),
        .i_rf_val    (r_rs2_val),
        .i_exmem_rd  (exmem_rd),
        .i_exmem_we  (exmem_regwrite),
        .i_exmem_val (exmem_result),
        .i_memwb_rd  (memwb_rd),
        .i_memwb_we  (memwb_regwrite),
        .i_memwb_val (memwb_result),
        .o_val       (w_fwd_rs2)
    );

    assign alu_data1     = w_fwd_rs1;
    assign alu_data2     = r_alusrc ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign alu_op        = r_aluop;
    assign ex_rd         = r_rd;
    assign ex_valid      = r_valid;
    assign ex_regwrite   = r_ctrl.regwrite;
    assign ex_memread    = r_ctrl.memread;
    assign ex_memwrite   = r_ctrl.memwrite;
    assign ex_memtoreg   = r_ctrl.memtoreg;
    assign ex_branch     = r_ctrl.branch;
    assign hazard_stall  = w_hazard;

`ifdef ID_EX_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Saturating count of hazard cycles; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_aluop;
    logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch;
    logic        stall, flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_regwrite, memwb_regwrite;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_data1, alu_data2, ex_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;
    logic        hazard_stall;
`ifdef ID_EX_STALL_CNT_EN
    logic [1:0]  stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(
        .XLEN   (32),
        .REG_AW (5)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .STALL_CNT_W (2)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs1_val     (id_rs1_val),
        .id_rs2_val     (id_rs2_val),
        .id_imm         (id_imm),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_aluop       (id_aluop),
        .id_alusrc      (id_alusrc),
        .id_regwrite    (id_regwrite),
        .id_memread     (id_memread),
        .id_memwrite    (id_memwrite),
        .id_memtoreg    (id_memtoreg),
        .id_branch      (id_branch),
        .stall          (stall),
        .flush          (flush),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_result   (exmem_result),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_result   (memwb_result),
        .alu_data1      (alu_data1),
        .alu_data2      (alu_data2),
        .alu_op         (alu_op),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_valid       (ex_valid),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_memtoreg    (ex_memtoreg),
        .ex_branch      (ex_branch),
        .hazard_stall   (hazard_stall)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    // ctrl bit order: {regwrite, memread, memwrite, memtoreg, branch}
    typedef struct {
        logic        valid;
        logic [31:0] rs1_val, rs2_val, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  aluop;
        logic        alusrc;
        logic [4:0]  ctrl;
        logic        flush;
        logic [4:0]  exm_rd;
        logic        exm_we;
        logic [31:0] exm_res;
        logic [4:0]  mwb_rd;
        logic        mwb_we;
        logic [31:0] mwb_res;
        logic [31:0] e_d1, e_d2, e_st;
        logic [3:0]  e_op;
        logic        e_valid;
        logic [4:0]  e_ctrl;
        logic [4:0]  e_rd;
        logic        e_hz;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [31:0] r1v, input logic [31:0] r2v,
                            input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd, input logic [3:0] op, input logic src,
                            input logic [4:0] ctrl);
        id_valid    = v;
        id_rs1_val  = r1v;
        id_rs2_val  = r2v;
        id_imm      = imm;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rd;
        id_aluop    = op;
        id_alusrc   = src;
        id_regwrite = ctrl[4];
        id_memread  = ctrl[3];
        id_memwrite = ctrl[2];
        id_memtoreg = ctrl[1];
        id_branch   = ctrl[0];
    endtask

    task automatic drive_fwd(input logic [4:0] erd, input logic ewe, input logic [31:0] eres,
                             input logic [4:0] mrd, input logic mwe, input logic [31:0] mres);
        exmem_rd       = erd;
        exmem_regwrite = ewe;
        exmem_result   = eres;
        memwb_rd       = mrd;
        memwb_regwrite = mwe;
        memwb_result   = mres;
    endtask

    // Idle slot plus one clock so no hazard leaks between sequences.
    task automatic idle_cycle();
        drive_id(1'b0, 0, 0, 0, 0, 0, 0, 4'h0, 1'b0, 5'b0);
        drive_fwd(0, 1'b0, 0, 0, 1'b0, 0);
        stall = 1'b0;
        flush = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [4:0] ex_ctrl_bits();
        return {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch};
    endfunction

    initial begin
        vecs[0] = '{1'b1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 4'h1, 1'b0, 5'b10000, 1'b0,
                    5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0,
                    32'd5, 32'd7, 32'd7, 4'h1, 1'b1, 5'b10000, 5'd3, 1'b0};
        vecs[1] = '{1'b1, 32'd5, 32'd7, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd3, 4'h0, 1'b1, 5'b10000, 1'b0,
                    5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0,
                    32'd5, 32'hFFFF_FFFC, 32'd7, 4'h0, 1'b1, 5'b10000, 5'd3, 1'b0};
        vecs[2] = '{1'b1, 32'hAA, 32'hBB, 32'd0, 5'd3, 5'd3, 5'd9, 4'h2, 1'b0, 5'b10000, 1'b0,
                    5'd3, 1'b1, 32'h10, 5'd3, 1'b1, 32'h20,
                    32'h10, 32'h10, 32'h10, 4'h2, 1'b1, 5'b10000, 5'd9, 1'b0};
        vecs[3] = '{1'b1, 32'hAA, 32'hBB, 32'd0, 5'd3, 5'd3, 5'd9, 4'h2, 1'b0, 5'b10000, 1'b0,
                    5'd3, 1'b0, 32'h10, 5'd3, 1'b1, 32'h20,
                    32'h20, 32'h20, 32'h20, 4'h2, 1'b1, 5'b10000, 5'd9, 1'b0};
        vecs[4] = '{1'b1, 32'h55, 32'h66, 32'd0, 5'd0, 5'd0, 5'd0, 4'h3, 1'b0, 5'b00000, 1'b0,
                    5'd0, 1'b1, 32'h10, 5'd0, 1'b1, 32'h20,
                    32'h55, 32'h66, 32'h66, 4'h3, 1'b1, 5'b00000, 5'd0, 1'b0};
        vecs[5] = '{1'b0, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd9, 4'h4, 1'b0, 5'b11101, 1'b0,
                    5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0,
                    32'd1, 32'd2, 32'd2, 4'h4, 1'b0, 5'b00000, 5'd9, 1'b0};
        vecs[6] = '{1'b1, 32'd1, 32'd2, 32'd0, 5'd4, 5'd5, 5'd6, 4'hF, 1'b0, 5'b00001, 1'b0,
                    5'd5, 1'b1, 32'h1234, 5'd4, 1'b1, 32'hDEAD_BEEF,
                    32'hDEAD_BEEF, 32'h1234, 32'h1234, 4'hF, 1'b1, 5'b00001, 5'd6, 1'b0};
        vecs[7] = '{1'b1, 32'h77, 32'h88, 32'd0, 5'd6, 5'd7, 5'd1, 4'h0, 1'b0, 5'b01010, 1'b0,
                    5'd6, 1'b0, 32'h1, 5'd7, 1'b0, 32'h2,
                    32'h77, 32'h88, 32'h88, 4'h0, 1'b1, 5'b01010, 5'd1, 1'b0};
        vecs[8] = '{1'b1, 32'h9, 32'hA, 32'hB, 5'd1, 5'd1, 5'd2, 4'h1, 1'b1, 5'b11111, 1'b1,
                    5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0,
                    32'd0, 32'd0, 32'd0, 4'h0, 1'b0, 5'b00000, 5'd0, 1'b0};

        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_id(1'b0, 0, 0, 0, 0, 0, 0, 4'h0, 1'b0, 5'b0);
        drive_fwd(0, 1'b0, 0, 0, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_op", 32'(alu_op), 32'd0);
        chk("rst_d1", alu_data1, 32'd0);
        chk("rst_d2", alu_data2, 32'd0);
        chk("rst_hz", 32'(hazard_stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: inputs applied at negedge, captured next posedge, checked next negedge.
        for (int i = 0; i < 9; i++) begin
            drive_id(vecs[i].valid, vecs[i].rs1_val, vecs[i].rs2_val, vecs[i].imm, vecs[i].rs1,
                     vecs[i].rs2, vecs[i].rd, vecs[i].aluop, vecs[i].alusrc, vecs[i].ctrl);
            drive_fwd(vecs[i].exm_rd, vecs[i].exm_we, vecs[i].exm_res,
                      vecs[i].mwb_rd, vecs[i].mwb_we, vecs[i].mwb_res);
            flush = vecs[i].flush;
            @(negedge clk);
            chk($sformatf("v%0d_d1", i), alu_data1, vecs[i].e_d1);
            chk($sformatf("v%0d_d2", i), alu_data2, vecs[i].e_d2);
            chk($sformatf("v%0d_st", i), ex_store_data, vecs[i].e_st);
            chk($sformatf("v%0d_op", i), 32'(alu_op), 32'(vecs[i].e_op));
            chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_ctrl", i), 32'(ex_ctrl_bits()), 32'(vecs[i].e_ctrl));
            chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_hz", i), 32'(hazard_stall), 32'(vecs[i].e_hz));
        end
        idle_cycle();

        // Load-use: lw x4 then consumer reading x4 via rs2.
        drive_id(1'b1, 0, 0, 0, 5'd1, 5'd2, 5'd4, 4'h0, 1'b1, 5'b11010);
        @(negedge clk);
        drive_id(1'b1, 32'h3, 32'h4, 0, 5'd7, 5'd4, 5'd8, 4'h0, 1'b0, 5'b10000);
        #1 chk("lu_hz", 32'(hazard_stall), 32'd1);
        @(negedge clk);
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_rd", 32'(ex_rd), 32'd0);
        chk("lu_hz_once", 32'(hazard_stall), 32'd0);
        @(negedge clk);
        chk("lu_cons_valid", 32'(ex_valid), 32'd1);
        chk("lu_cons_rd", 32'(ex_rd), 32'd8);
        idle_cycle();

        // Load into x0 never stalls.
        drive_id(1'b1, 0, 0, 0, 5'd1, 5'd2, 5'd0, 4'h0, 1'b1, 5'b11010);
        @(negedge clk);
        drive_id(1'b1, 0, 0, 0, 5'd0, 5'd0, 5'd8, 4'h0, 1'b0, 5'b10000);
        #1 chk("rd0_hz", 32'(hazard_stall), 32'd0);
        idle_cycle();

        // Empty decode slot never stalls.
        drive_id(1'b1, 0, 0, 0, 5'd1, 5'd2, 5'd4, 4'h0, 1'b1, 5'b11010);
        @(negedge clk);
        drive_id(1'b0, 0, 0, 0, 5'd4, 5'd4, 5'd8, 4'h0, 1'b0, 5'b10000);
        #1 chk("idinv_hz", 32'(hazard_stall), 32'd0);
        idle_cycle();

        // Flush suppresses a live hazard (rs1 match) and loads a bubble.
        drive_id(1'b1, 0, 0, 0, 5'd1, 5'd2, 5'd4, 4'h0, 1'b1, 5'b11010);
        @(negedge clk);
        drive_id(1'b1, 32'h3, 32'h4, 0, 5'd4, 5'd9, 5'd8, 4'h0, 1'b0, 5'b10000);
        #1 chk("fl_hz_pre", 32'(hazard_stall), 32'd1);
        flush = 1'b1;
        #1 chk("fl_hz_sup", 32'(hazard_stall), 32'd0);
        @(negedge clk);
        chk("fl_valid", 32'(ex_valid), 32'd0);
        idle_cycle();

        // Stall holds all fields for three cycles, then stall+flush bubbles.
        drive_id(1'b1, 32'h11, 32'h22, 0, 5'd1, 5'd2, 5'd5, 4'h3, 1'b0, 5'b10000);
        @(negedge clk);
        stall = 1'b1;
        drive_id(1'b1, 32'h99, 32'h98, 0, 5'd3, 5'd6, 5'd7, 4'h4, 1'b0, 5'b10000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_d1", c), alu_data1, 32'h11);
            chk($sformatf("hold%0d_rd", c), 32'(ex_rd), 32'd5);
            chk($sformatf("hold%0d_op", c), 32'(alu_op), 32'd3);
            chk($sformatf("hold%0d_valid", c), 32'(ex_valid), 32'd1);
        end
        flush = 1'b1;
        @(negedge clk);
        chk("stfl_valid", 32'(ex_valid), 32'd0);
        chk("stfl_rd", 32'(ex_rd), 32'd0);
        idle_cycle();

        // Asynchronous reset mid-stream.
        drive_id(1'b1, 32'h5, 32'h7, 0, 5'd1, 5'd2, 5'd3, 4'h1, 1'b0, 5'b11000);
        @(negedge clk);
        chk("pre_rst_valid", 32'(ex_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_op", 32'(alu_op), 32'd0);
        chk("arst_rd", 32'(ex_rd), 32'd0);
        chk("arst_ctrl", 32'(ex_ctrl_bits()), 32'd0);
        chk("arst_d1", alu_data1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();

`ifdef ID_EX_STALL_CNT_EN
        // Hazard held under stall for three cycles, then one more hazard edge saturates.
        drive_id(1'b1, 0, 0, 0, 5'd1, 5'd2, 5'd4, 4'h0, 1'b1, 5'b11010);
        @(negedge clk);
        chk("cnt_start", 32'(stall_count), 32'd0);
        drive_id(1'b1, 0, 0, 0, 5'd4, 5'd4, 5'd8, 4'h0, 1'b0, 5'b10000);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        chk("cnt_three", 32'(stall_count), 32'd3);
        stall = 1'b0;
        @(negedge clk);
        chk("cnt_sat", 32'(stall_count), 32'd3);
        idle_cycle();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
